spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave that oversamples CS, SCLK and SDI on CTRL_CLK and supports all four SPI modes, a configurable word width and back-to-back multi-word transfers within one CS assertion. It presents ready/valid streams toward the local controller for transmit and receive words, with overrun and underrun reporting. It is the next-generation replacement for the fixed 8-bit, mode-0 slave, and sits between the SPI pins and the slave-side data store or ROM.

## Interface
- DATA_W, 8, word width in bits (≥2); transfers are MSB first
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
- SYNC_STAGES, 2, synchroniser depth for CS, SCLK and SDI (≥2)
- CTRL_CLK  in  1  system clock; all logic is on its rising edge
- NRST  in  1  reset, synchronous, active-low; clock CTRL_CLK
- CS  in  1  chip select from master, active-low, asynchronous
- SCLK  in  1  SPI clock from master, asynchronous
- SDI  in  1  serial data from master
- SDO  out  1  serial data to master, registered
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data holds a valid word
- tx_ready  out  1  one-cycle pulse; tx_data is consumed in this cycle when tx_valid=1
- rx_data  out  DATA_W  last received word
- rx_valid  out  1  rx_data valid; held until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  high in ACTIVE state
- overrun  out  1  sticky; a word completed while rx_valid was still high
- underrun  out  1  one-cycle pulse; a word load found tx_valid=0

## Operation
- Reset values: SDO=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, overrun=0, underrun=0; synchroniser resets are CS=1, SCLK=CPOL, SDI=0; state=IDLE; bit_cnt=0.
- Edge detection on synchronised SCLK:
  - Leading edge: SCLK moves from CPOL to !CPOL.
  - Trailing edge: SCLK returns to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other one.
- IDLE:
  - SCLK edges are ignored and SDO=0.
  - A synchronised CS falling edge moves to ACTIVE with bit_cnt=0.
  - If CPHA=0, a word load also happens in this cycle.
- ACTIVE:
  - Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], SDI_sync}, then bit_cnt <= bit_cnt+1. When bit_cnt reaches DATA_W it wraps to 0 and the word completes.
  - Shift edge with bit_cnt=0: word load.
  - Shift edge with bit_cnt≠0: tx_shift <= tx_shift<<1.
  - SDO <= tx_shift MSB after every load or shift.
- Word load:
  - If tx_valid=1: tx_shift <= tx_data and tx_ready pulses.
  - If tx_valid=0: tx_shift <= 0 and underrun pulses.
- Word complete:
  - rx_data <= assembled word and rx_valid <= 1.
  - If rx_valid was already 1 and rx_ready=0 in the same cycle, overrun <= 1 and the new word overwrites rx_data.
- rx_valid clears on rx_valid & rx_ready, unless a word completes in the same cycle; completion wins, rx_valid stays 1 and no overrun is set.
- overrun clears only at the next CS falling edge or on reset.
- CS rising edge (synchronised), at any point:
  - Go to IDLE, SDO <= 0, bit_cnt <= 0.
  - The partial word is discarded, with no rx_valid and no overrun.
  - rx_valid, rx_data and overrun keep their values.
- Consecutive words within one CS assertion need no gap. The load for word n+1 occurs on the first shift edge after word n completes.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 CTRL_CLK cycles from an SCLK or CS pin change to the internal edge-detect pulse.
- Action latency: the action (sample, shift or load) happens in the detect cycle.
- SDO changes 1 cycle after the detect cycle.
- rx_valid rises 1 cycle after the detect cycle of the DATA_W-th sample edge.
- tx_ready and underrun are asserted in the detect cycle of the load.
- Constraints:
  - Each SCLK high and low phase must be ≥ SYNC_STAGES+2 CTRL_CLK cycles.
  - CS must fall ≥ SYNC_STAGES+2 cycles before the first SCLK edge.
- NRST low in any state: all outputs return to reset values on the next CTRL_CLK edge, with no partial-word output.

## Test plan
- Mode 0, DATA_W=8, tx_data=0xA5 with tx_valid held, master sends 0x3C, CS rises after 8 clocks -> SDO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1; one tx_ready pulse; overrun=0.
- Each of modes 1, 2 and 3 with tx=0x5A and master sending 0xC3 -> master samples 0x5A and rx_data=0xC3, checked in all modes.
- DATA_W=16, mode 0, 3 back-to-back words 0x1234, 0xABCD, 0x0F0F with rx_ready tied high -> three rx_valid events with matching rx_data and three tx_ready pulses.
- Two words received with rx_ready=0 -> overrun=1 and rx_data equals the second word. Next CS fall -> overrun=0.
- tx_valid=0 at the second word load -> underrun pulses once, SDO=0 for that whole word, first word unaffected.
- CS rises after 5 bits; separately, NRST is asserted after 3 bits -> no rx_valid, busy=0, SDO=0. A following full transfer of 0x81 is received correctly.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with configurable mode and word width that
// oversamples CS/SCLK/SDI on CTRL_CLK and exposes ready/valid word streams.
//
// Ports:
//   CTRL_CLK, NRST        system clock, synchronous active-low reset
//   CS, SCLK, SDI         SPI pins from master (asynchronous)
//   SDO                   serial data to master (registered)
//   tx_data/tx_valid      next word to transmit; tx_ready pulses on consume
//   rx_data/rx_valid      received word, held until rx_ready
//   busy                  transfer in progress (ACTIVE state)
//   overrun               sticky: word completed while rx_valid still pending
//   underrun              pulse: word load found no valid tx word
module spi_slave_param #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CTRL_CLK,
    input  logic              NRST,
    input  logic              CS,
    input  logic              SCLK,
    input  logic              SDI,
    output logic              SDO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync;
    logic cs_s, sclk_s, sdi_s;
    logic cs_q, sclk_q;
    logic cs_fall_q, cs_rise_q, lead_q, trail_q;
    logic sample_e, shift_e;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] tx_shift;   // bits still to send after the one on SDO
    logic [DATA_W-2:0] rx_shift;   // bits assembled so far, MSB first
    logic [DATA_W-1:0] rx_next;

    logic start, stop, load, do_sample, do_shift, word_done;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // Pin synchronisers
    always_ff @(posedge CTRL_CLK) begin
        if (!NRST) begin
            cs_sync   <= '1;
            sclk_sync <= {SYNC_STAGES{CPOL}};
            sdi_sync  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
        end
    end

    // Registered edge-detect pulses; their high cycle is the detect cycle
    always_ff @(posedge CTRL_CLK) begin
        if (!NRST) begin
            cs_q      <= 1'b1;
            sclk_q    <= CPOL;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
        end else begin
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
            cs_fall_q <= cs_q & ~cs_s;
            cs_rise_q <= ~cs_q & cs_s;
            lead_q    <= (sclk_q == CPOL) && (sclk_s != CPOL);
            trail_q   <= (sclk_q != CPOL) && (sclk_s == CPOL);
        end
    end

    assign sample_e = CPHA ? trail_q : lead_q;
    assign shift_e  = CPHA ? lead_q  : trail_q;

    // State register
    always_ff @(posedge CTRL_CLK) begin
        if (!NRST) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall_q) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-cycle actions decoded from state and edge pulses
    always_comb begin
        start     = 1'b0;
        stop      = 1'b0;
        load      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_q) begin
                    start = 1'b1;
                    load  = ~CPHA;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    stop = 1'b1;
                end else begin
                    do_sample = sample_e;
                    if (shift_e) begin
                        load     = (bit_cnt == '0);
                        do_shift = (bit_cnt != '0);
                    end
                end
            end
            default: ;
        endcase
    end

    assign word_done = do_sample && (bit_cnt == LAST_BIT);
    assign rx_next   = {rx_shift, sdi_s};
    assign tx_ready  = load & tx_valid;
    assign underrun  = load & ~tx_valid;
    assign busy      = (state == ACTIVE);

    // Shift datapath and receive handshake
    always_ff @(posedge CTRL_CLK) begin
        if (!NRST) begin
            SDO      <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                tx_shift <= tx_valid ? tx_data[DATA_W-2:0] : '0;
                SDO      <= tx_valid & tx_data[DATA_W-1];
            end else if (do_shift) begin
                tx_shift <= tx_shift << 1;
                SDO      <= tx_shift[DATA_W-2];
            end

            if (do_sample) begin
                rx_shift <= rx_next[DATA_W-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (start || stop) bit_cnt <= '0;
            if (stop)          SDO     <= 1'b0;

            // Completion beats a same-cycle consume
            if (word_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (start)
                overrun <= 1'b0;
            else if (word_done && rx_valid && !rx_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: drives four 8-bit instances (modes 0..3) and one
// 16-bit mode-0 instance with a behavioural SPI master; expected words come
// from a word-level model (each master word is received, each slave word is
// returned, or zero when no tx word was offered).
module tb_spi_slave_param;

    localparam int H = 8;   // SCLK half period in CTRL_CLK cycles

    logic       clk = 1'b0;
    logic       nrst;
    logic       cs [5];
    logic       sclk [5];
    logic       sdi [5];
    logic       sdo [5];
    logic       tx_valid [5];
    logic       tx_ready [5];
    logic       rx_valid [5];
    logic       rx_ready [5];
    logic       busy [5];
    logic       overrun [5];
    logic       underrun [5];
    logic [7:0] tx_data8 [4];
    logic [7:0] rx_data8 [4];
    logic [15:0] tx_data16, rx_data16;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_param #(
            .DATA_W(8), .CPOL(1'((g >> 1) & 1)), .CPHA(1'(g & 1)), .SYNC_STAGES(2)
        ) dut (
            .CTRL_CLK(clk), .NRST(nrst), .CS(cs[g]), .SCLK(sclk[g]), .SDI(sdi[g]),
            .SDO(sdo[g]), .tx_data(tx_data8[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data8[g]), .rx_valid(rx_valid[g]),
            .rx_ready(rx_ready[g]), .busy(busy[g]), .overrun(overrun[g]),
            .underrun(underrun[g])
        );
    end

    spi_slave_param #(
        .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)
    ) dut16 (
        .CTRL_CLK(clk), .NRST(nrst), .CS(cs[4]), .SCLK(sclk[4]), .SDI(sdi[4]),
        .SDO(sdo[4]), .tx_data(tx_data16), .tx_valid(tx_valid[4]),
        .tx_ready(tx_ready[4]), .rx_data(rx_data16), .rx_valid(rx_valid[4]),
        .rx_ready(rx_ready[4]), .busy(busy[4]), .overrun(overrun[4]),
        .underrun(underrun[4])
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] mosi_q[$], txw_q[$], miso_q[$], rx_q[$], exp_miso_q[$], exp_rx_q[$];
    bit          txv_q[$];
    int          txr_cnt, und_cnt, exp_txr, exp_und;
    bit          adv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 4) ? 16 : 8;
    endfunction

    function automatic bit cpol_of(input int i);
        return (i < 4) ? 1'((i >> 1) & 1) : 1'b0;
    endfunction

    function automatic bit cpha_of(input int i);
        return (i < 4) ? 1'(i & 1) : 1'b0;
    endfunction

    function automatic logic [15:0] get_rx(input int i);
        return (i == 4) ? rx_data16 : {8'h00, rx_data8[i]};
    endfunction

    task automatic set_tx(input int i);
        logic [15:0] d;
        bit          v;
        d = '0;
        v = 1'b0;
        if (txw_q.size() > 0) begin
            d = txw_q[0];
            v = txv_q[0];
        end
        if (i == 4) tx_data16 = d;
        else        tx_data8[i] = d[7:0];
        tx_valid[i] = v;
    endtask

    task automatic advance_tx(input int i);
        if (txw_q.size() > 0) begin
            void'(txw_q.pop_front());
            void'(txv_q.pop_front());
        end
        set_tx(i);
    endtask

    // Advance n cycles, feeding tx words and logging handshakes of instance i
    task automatic tick(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                advance_tx(i);
            end
            if (tx_ready[i]) begin txr_cnt++; adv = 1'b1; end
            if (underrun[i]) begin und_cnt++; adv = 1'b1; end
            if (rx_valid[i] && rx_ready[i]) rx_q.push_back(get_rx(i));
        end
    endtask

    task automatic clear_words();
        mosi_q.delete(); txw_q.delete(); txv_q.delete();
        exp_miso_q.delete(); exp_rx_q.delete();
        exp_txr = 0;
        exp_und = 0;
    endtask

    // Word-level model: master word is received; slave word is returned or zero
    task automatic add_word(input logic [15:0] m, input logic [15:0] t, input bit v);
        mosi_q.push_back(m);
        txw_q.push_back(t);
        txv_q.push_back(v);
        exp_rx_q.push_back(m);
        exp_miso_q.push_back(v ? t : 16'h0000);
        if (v) exp_txr++;
        else   exp_und++;
    endtask

    // Behavioural SPI master: nbits clocks, then CS rise (or reset if rst_end)
    task automatic xfer(input int i, input int nbits, input bit rst_end);
        int          w;
        bit          cpol, cpha;
        logic [15:0] got;
        w    = width_of(i);
        cpol = cpol_of(i);
        cpha = cpha_of(i);
        miso_q.delete();
        rx_q.delete();
        txr_cnt = 0;
        und_cnt = 0;
        adv     = 1'b0;
        got     = '0;
        set_tx(i);
        sclk[i] = cpol;
        if (!cpha) sdi[i] = mosi_q[0][w-1];
        cs[i] = 1'b0;
        tick(i, H);
        for (int b = 0; b < nbits; b++) begin
            int          k, p, kn, pn;
            logic [15:0] cur, nxt;
            k   = b / w;
            p   = w - 1 - (b % w);
            cur = mosi_q[k];
            if (!cpha) begin
                got     = {got[14:0], sdo[i]};
                sclk[i] = ~cpol;
                tick(i, H);
                if (p == 0) begin miso_q.push_back(got); got = '0; end
                if (b == nbits - 1) break;
                kn      = (b + 1) / w;
                pn      = w - 1 - ((b + 1) % w);
                nxt     = mosi_q[kn];
                sclk[i] = cpol;
                sdi[i]  = nxt[pn];
                tick(i, H);
            end else begin
                sclk[i] = ~cpol;
                sdi[i]  = cur[p];
                tick(i, H);
                got     = {got[14:0], sdo[i]};
                sclk[i] = cpol;
                tick(i, H);
                if (p == 0) begin miso_q.push_back(got); got = '0; end
            end
        end
        if (rst_end) begin
            nrst  = 1'b0;
            cs[i] = 1'b1;
            tick(i, 3);
            nrst  = 1'b1;
        end else begin
            cs[i] = 1'b1;
        end
        tick(i, H);
        sclk[i] = cpol;
        tick(i, H);
    endtask

    task automatic verify(input string tag, input int i, input bit rxq_on);
        check({tag, " miso_count"}, 32'(miso_q.size()), 32'(exp_miso_q.size()));
        for (int k = 0; k < exp_miso_q.size() && k < miso_q.size(); k++)
            check({tag, " miso_word"}, 32'(miso_q[k]), 32'(exp_miso_q[k]));
        if (rxq_on) begin
            check({tag, " rx_count"}, 32'(rx_q.size()), 32'(exp_rx_q.size()));
            for (int k = 0; k < exp_rx_q.size() && k < rx_q.size(); k++)
                check({tag, " rx_word"}, 32'(rx_q[k]), 32'(exp_rx_q[k]));
        end
        check({tag, " tx_ready_count"}, 32'(txr_cnt), 32'(exp_txr));
        check({tag, " underrun_count"}, 32'(und_cnt), 32'(exp_und));
        check({tag, " busy_idle"}, 32'(busy[i]), 32'd0);
        check({tag, " sdo_idle"}, 32'(sdo[i]), 32'd0);
    endtask

    initial begin
        nrst      = 1'b0;
        tx_data16 = '0;
        for (int i = 0; i < 5; i++) begin
            cs[i]       = 1'b1;
            sclk[i]     = cpol_of(i);
            sdi[i]      = 1'b0;
            tx_valid[i] = 1'b0;
            rx_ready[i] = 1'b1;
            if (i < 4) tx_data8[i] = '0;
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state of every instance
        for (int i = 0; i < 5; i++) begin
            check("reset sdo", 32'(sdo[i]), 32'd0);
            check("reset tx_ready", 32'(tx_ready[i]), 32'd0);
            check("reset rx_data", 32'(get_rx(i)), 32'd0);
            check("reset rx_valid", 32'(rx_valid[i]), 32'd0);
            check("reset busy", 32'(busy[i]), 32'd0);
            check("reset overrun", 32'(overrun[i]), 32'd0);
            check("reset underrun", 32'(underrun[i]), 32'd0);
        end

        // Mode 0: slave sends A5, master sends 3C, rx_valid held
        rx_ready[0] = 1'b0;
        clear_words();
        add_word(16'h003C, 16'h00A5, 1'b1);
        xfer(0, 8, 1'b0);
        verify("mode0", 0, 1'b0);
        check("mode0 rx_data", 32'(get_rx(0)), 32'h3C);
        check("mode0 rx_valid", 32'(rx_valid[0]), 32'd1);
        check("mode0 overrun", 32'(overrun[0]), 32'd0);
        rx_ready[0] = 1'b1;
        tick(0, 2);
        check("mode0 rx_valid_drain", 32'(rx_valid[0]), 32'd0);

        // Modes 1..3: slave sends 5A, master sends C3
        for (int i = 1; i < 4; i++) begin
            clear_words();
            add_word(16'h00C3, 16'h005A, 1'b1);
            xfer(i, 8, 1'b0);
            verify($sformatf("mode%0d", i), i, 1'b1);
        end

        // 16-bit back-to-back words within one CS
        clear_words();
        add_word(16'h1234, 16'hBEEF, 1'b1);
        add_word(16'hABCD, 16'h1357, 1'b1);
        add_word(16'h0F0F, 16'hF00D, 1'b1);
        xfer(4, 48, 1'b0);
        verify("w16_b2b", 4, 1'b1);

        // Overrun: two words with rx_ready low, cleared by next CS fall
        rx_ready[0] = 1'b0;
        clear_words();
        add_word(16'h0011, 16'h0033, 1'b1);
        add_word(16'h0022, 16'h0044, 1'b1);
        xfer(0, 16, 1'b0);
        verify("ovr", 0, 1'b0);
        check("ovr overrun", 32'(overrun[0]), 32'd1);
        check("ovr rx_data", 32'(get_rx(0)), 32'h22);
        check("ovr rx_valid", 32'(rx_valid[0]), 32'd1);
        cs[0] = 1'b0;
        tick(0, H);
        check("ovr cleared_on_cs_fall", 32'(overrun[0]), 32'd0);
        check("ovr busy_active", 32'(busy[0]), 32'd1);
        cs[0] = 1'b1;
        tick(0, H);
        check("ovr busy_after", 32'(busy[0]), 32'd0);
        rx_ready[0] = 1'b1;
        tick(0, 2);
        check("ovr rx_valid_drain", 32'(rx_valid[0]), 32'd0);

        // Underrun on the second word load
        clear_words();
        add_word(16'h0096, 16'h00A5, 1'b1);
        add_word(16'h0069, 16'h00FF, 1'b0);
        xfer(0, 16, 1'b0);
        verify("underrun", 0, 1'b1);

        // CS abort after 5 bits, then a full 0x81 transfer
        for (int i = 0; i < 2; i++) begin
            clear_words();
            add_word(16'h00B7, 16'h00C9, 1'b1);
            exp_rx_q.delete();
            exp_miso_q.delete();
            xfer(i, 5, 1'b0);
            verify($sformatf("abort%0d", i), i, 1'b1);
            check("abort rx_valid", 32'(rx_valid[i]), 32'd0);
            clear_words();
            add_word(16'h0081, 16'h007E, 1'b1);
            xfer(i, 8, 1'b0);
            verify($sformatf("after_abort%0d", i), i, 1'b1);
        end

        // Reset after 3 bits, then a full 0x81 transfer
        clear_words();
        add_word(16'h00E4, 16'h0055, 1'b1);
        exp_rx_q.delete();
        exp_miso_q.delete();
        xfer(0, 3, 1'b1);
        verify("rst_mid", 0, 1'b1);
        check("rst_mid rx_valid", 32'(rx_valid[0]), 32'd0);
        check("rst_mid overrun", 32'(overrun[0]), 32'd0);
        clear_words();
        add_word(16'h0081, 16'h0018, 1'b1);
        xfer(0, 8, 1'b0);
        verify("after_rst", 0, 1'b1);

        // Randomized multi-word transfers across all instances
        for (int r = 0; r < 24; r++) begin
            int          i, n;
            logic [15:0] mask;
            i    = int'($urandom_range(0, 4));
            n    = int'($urandom_range(1, 3));
            mask = (width_of(i) == 16) ? 16'hFFFF : 16'h00FF;
            clear_words();
            for (int k = 0; k < n; k++)
                add_word(16'($urandom) & mask, 16'($urandom) & mask,
                         ($urandom_range(0, 3) != 0));
            xfer(i, n * width_of(i), 1'b0);
            verify($sformatf("rand%0d_inst%0d", r, i), i, 1'b1);
            check("rand overrun", 32'(overrun[i]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
